// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = loader side, slave = stream source / memory side.
`timescale 1ns/1ps
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a length/data/checksum byte frame,
// writes little-endian words and releases the core only after a verified image.
`timescale 1ns/1ps
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      len_q, len_d;
  logic [7:0]       csum_q, csum_d;
  logic [31:0]      word_q, word_d;
  logic             rx_ready_q, rx_ready_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             core_reset_q, core_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             accept;
  logic [31:0]      len_ins;
  logic [31:0]      word_ins;
  logic             last_word;
  logic             in_load;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    len_d        = len_q;
    csum_d       = csum_q;
    word_d       = word_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    accept       = bus.rx_valid && rx_ready_q;
    len_ins      = len_q;
    len_ins[{byte_cnt_q, 3'b000} +: 8]  = bus.rx_data;
    word_ins     = word_q;
    word_ins[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
    last_word    = (32'(word_idx_q) + 32'd1) == len_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
          len_d      = 32'd0;
          csum_d     = 8'd0;
          word_d     = 32'd0;
        end
      end

      S_LEN: begin
        if (accept) begin
          len_d      = len_ins;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (len_ins > 32'(DEPTH_WORDS)) begin
              state_d = S_ERR;
            end else if (len_ins == 32'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d     = word_ins;
          csum_d     = csum_q ^ bus.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth lane completes the word: write it and advance the index
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = BASE_ADDR + 32'({word_idx_q, 2'b00});
            wr_data_d  = word_ins;
            word_idx_d = word_idx_q + IDX_W'(1);
            if (last_word) begin
              state_d = S_CSUM;
            end
          end
        end
      end

      S_CSUM: begin
        if (accept) begin
          state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered views of the state being entered
    in_load      = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    rx_ready_d   = in_load;
    busy_d       = in_load;
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    core_reset_d = (state_d != S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= '0;
      len_q        <= 32'd0;
      csum_q       <= 8'd0;
      word_q       <= 32'd0;
      rx_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= 32'd0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
      rx_ready_q   <= rx_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign core_reset   = core_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
